// File: rtl/pipelined_adder.sv
// pipelined_adder: a WIDTH-bit adder/subtractor split into STAGES = WIDTH/CHUNK pipeline
// stages. Each stage adds one CHUNK-wide slice and passes its carry to the next stage.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set a/b/cin/sub is presented
//   in_ready   block can accept an operand set (low only while the output stage is stalled)
//   a, b       WIDTH-bit unsigned operands
//   cin        carry-in, used only in add mode
//   sub        0 = a + b + cin, 1 = a - b (a + ~b + 1)
//   out_valid  sum/ovf hold a valid result
//   out_ready  consumer takes the result this cycle
//   sum        {carry-out, WIDTH-bit result}; in subtract mode sum[WIDTH]=1 means no borrow
//   ovf        two's-complement overflow of the WIDTH-bit result
//   busy       at least one stage holds a valid transaction
//
// WIDTH must be a multiple of CHUNK, and CHUNK must be at least 1.
module pipelined_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned STAGES = WIDTH / CHUNK;

   // Per-stage state. Operands travel in full so the final stage still has the operand MSBs
   // for the overflow rule; slices already consumed are left for synthesis to trim.
   logic [STAGES-1:0] r_vld;
   logic [WIDTH-1:0]  r_opa [STAGES];
   logic [WIDTH-1:0]  r_opb [STAGES];  // b after the subtract-mode inversion
   logic [WIDTH-1:0]  r_res [STAGES];  // result slices produced so far
   logic              r_cy  [STAGES];  // carry out of this stage's slice
   logic              r_armed;

   logic             w_stall;
   logic             w_adv;
   logic             w_take;
   logic [WIDTH-1:0] w_opb;
   logic             w_cin0;
   logic [CHUNK:0]   w_csum  [STAGES];
   logic [WIDTH-1:0] w_nxt_a [STAGES];
   logic [WIDTH-1:0] w_nxt_b [STAGES];
   logic [WIDTH-1:0] w_nxt_r [STAGES];
   logic             w_nxt_c [STAGES];

   // The whole pipeline moves as one; only a full output stage that is not taken blocks it.
   assign w_stall = r_vld[STAGES-1] & ~out_ready;
   assign w_adv   = ~w_stall;
   assign in_ready = ~w_stall;

   // r_armed is clear until the first edge after reset release, so that edge never accepts.
   assign w_take = in_valid & r_armed;

   always_comb begin
      w_opb  = sub ? ~b : b;
      w_cin0 = sub ? 1'b1 : cin;

      for (int k = 0; k < int'(STAGES); k++) begin
         w_csum[k]  = '0;
         w_nxt_a[k] = '0;
         w_nxt_b[k] = '0;
         w_nxt_r[k] = '0;
         w_nxt_c[k] = 1'b0;
      end

      // Stage 0 works straight from the ports.
      w_csum[0]  = {1'b0, a[CHUNK-1:0]} + {1'b0, w_opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_cin0};
      w_nxt_a[0] = a;
      w_nxt_b[0] = w_opb;
      w_nxt_r[0][CHUNK-1:0] = w_csum[0][CHUNK-1:0];
      w_nxt_c[0] = w_csum[0][CHUNK];

      // Stage k adds its slice of the delayed operands plus the registered carry of stage k-1.
      for (int k = 1; k < int'(STAGES); k++) begin
         w_csum[k] = {1'b0, r_opa[k-1][k*CHUNK +: CHUNK]}
                   + {1'b0, r_opb[k-1][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, r_cy[k-1]};
         w_nxt_a[k] = r_opa[k-1];
         w_nxt_b[k] = r_opb[k-1];
         w_nxt_r[k] = r_res[k-1];
         w_nxt_r[k][k*CHUNK +: CHUNK] = w_csum[k][CHUNK-1:0];
         w_nxt_c[k] = w_csum[k][CHUNK];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
         r_vld   <= '0;
         for (int k = 0; k < int'(STAGES); k++) begin
            r_opa[k] <= '0;
            r_opb[k] <= '0;
            r_res[k] <= '0;
            r_cy[k]  <= 1'b0;
         end
      end else begin
         r_armed <= 1'b1;
         if (w_adv) begin
            r_vld[0] <= w_take;
            for (int k = 1; k < int'(STAGES); k++) begin
               r_vld[k] <= r_vld[k-1];
            end
            // Data loads only behind a valid entry, so bubbles never disturb sum/ovf.
            if (w_take) begin
               r_opa[0] <= w_nxt_a[0];
               r_opb[0] <= w_nxt_b[0];
               r_res[0] <= w_nxt_r[0];
               r_cy[0]  <= w_nxt_c[0];
            end
            for (int k = 1; k < int'(STAGES); k++) begin
               if (r_vld[k-1]) begin
                  r_opa[k] <= w_nxt_a[k];
                  r_opb[k] <= w_nxt_b[k];
                  r_res[k] <= w_nxt_r[k];
                  r_cy[k]  <= w_nxt_c[k];
               end
            end
         end
      end
   end

   assign out_valid = r_vld[STAGES-1];
   assign busy      = |r_vld;
   assign sum       = {r_cy[STAGES-1], r_res[STAGES-1]};
   // Overflow: operand MSBs agree but the result MSB does not.
   assign ovf = (r_opa[STAGES-1][WIDTH-1] == r_opb[STAGES-1][WIDTH-1])
              & (r_res[STAGES-1][WIDTH-1] != r_opa[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table, stall/reset sequences,
// randomized stream against an arithmetic reference model, and a single-stage instance.
module tb_pipelined_adder;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [16:0] sum;
      logic        ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, ovf, busy;
   logic [15:0] a, b;
   logic [16:0] sum;

   logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, ovf8, busy8;
   logic [7:0]  a8, b8;
   logic [8:0]  sum8;

   int          n_chk = 0;
   int          n_fail = 0;
   int          n_out = 0;
   int          n_acc = 0;
   logic [17:0] q[$];
   vec_t        vt[5];

   pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .ovf(ovf), .busy(busy)
   );

   pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
      .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
      .ovf(ovf8), .busy(busy8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: unsigned result from plain integer arithmetic, overflow from signed ranges.
   function automatic void model(input int w, input longint ua, input longint ub,
                                 input bit c, input bit s, output longint sm, output bit ov);
      longint md, hf, sa, sb, r;
      md = longint'(1) << w;
      hf = md / 2;
      sm = s ? (ua - ub + md) : (ua + ub + longint'(c));
      sa = (ua >= hf) ? ua - md : ua;
      sb = (ub >= hf) ? ub - md : ub;
      r  = s ? (sa - sb) : (sa + sb + longint'(c));
      ov = (r >= hf) || (r < -hf);
   endfunction

   function automatic logic [17:0] expect16(input logic [15:0] ua, input logic [15:0] ub,
                                            input logic c, input logic s);
      longint sm;
      bit     ov;
      model(16, longint'(ua), longint'(ub), c, s, sm, ov);
      return {ov, sm[16:0]};
   endfunction

   // Called #1 after a negedge with inputs already driven; returns after the next posedge.
   task automatic sb_step(output bit acc);
      bit pop;
      if (out_valid) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_spurious: got out_valid=1, expected 0 (no result pending)");
         end else begin
            chk("sb_result", {46'd0, ovf, sum}, {46'd0, q[0]});
         end
      end
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      @(posedge clk);
      if (acc) q.push_back(expect16(a, b, cin, sub));
      if (pop && q.size() > 0) begin
         void'(q.pop_front());
         n_out++;
      end
   endtask

   // One isolated transaction; checks E3 latency, single-cycle out_valid and held sum.
   task automatic run_vec(input int i);
      @(negedge clk);
      a = vt[i].a; b = vt[i].b; cin = vt[i].cin; sub = vt[i].sub;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);                        // E0
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);             // E2
      #1 chk($sformatf("vec%0d_early", i), out_valid, 0);
      @(posedge clk);                        // E3
      #1;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_sum", i), sum, vt[i].sum);
      chk($sformatf("vec%0d_ovf", i), ovf, vt[i].ovf);
      @(posedge clk);                        // E4
      #1;
      chk($sformatf("vec%0d_once", i), out_valid, 0);
      chk($sformatf("vec%0d_hold", i), sum, vt[i].sum);
   endtask

   initial begin
      bit          acc;
      int          idx;
      logic [15:0] sa[8], sb[8];
      logic [17:0] e1;
      longint      sm8;
      bit          ov8;

      vt[0] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 17'h02346, 1'b0};
      vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0};
      vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1};
      vt[3] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 17'h0FFFF, 1'b0};
      vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1};

      rst_n = 1'b0;
      in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
      in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; out_ready8 = 1;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", sum, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst8_sum", sum8, 0);
      chk("rst8_out_valid", out_valid8, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);

      // Directed table
      for (int i = 0; i < 5; i++) run_vec(i);

      // Eight back-to-back operand sets with a three-cycle stall mid-stream
      q.delete();
      n_out = 0;
      for (int i = 0; i < 8; i++) begin
         sa[i] = 16'($urandom);
         sb[i] = 16'($urandom);
      end
      e1 = expect16(sa[1], sb[1], 1'b0, 1'b0);
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         in_valid  = (idx < 8);
         a         = sa[idx % 8];
         b         = sb[idx % 8];
         cin       = 1'b0;
         sub       = 1'b0;
         out_ready = !(c >= 5 && c <= 7);
         #1;
         if (c >= 5 && c <= 7) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_hold", {46'd0, ovf, sum}, {46'd0, e1});
         end
         sb_step(acc);
         if (acc) idx++;
      end
      chk("stream_accepted", idx, 8);
      chk("stream_delivered", n_out, 8);

      // Randomized traffic with random back-pressure
      q.delete();
      n_out = 0;
      n_acc = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a   = 16'($urandom);
         b   = 16'($urandom);
         cin = 1'($urandom);
         sub = 1'($urandom);
         #1;
         sb_step(acc);
         if (acc) n_acc++;
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         in_valid  = 1'b0;
         out_ready = 1'b1;
         #1;
         sb_step(acc);
      end
      chk("rand_drained", q.size(), 0);
      chk("rand_count", n_out, n_acc);
      chk("rand_idle", busy, 0);

      // Reset with three transactions in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; out_ready = 1'b1;
         a = 16'h0100 * 16'(i + 1); b = 16'h0011; cin = 0; sub = 0;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("inflight_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1 chk("no_ghost", out_valid, 0);
      end
      run_vec(2);

      // Single-stage instance: result visible right after the accepting edge
      @(negedge clk);
      a8 = 8'hF0; b8 = 8'h20; cin8 = 0; sub8 = 0; in_valid8 = 1;
      @(posedge clk);
      #1;
      chk("s1_valid", out_valid8, 1);
      chk("s1_sum", sum8, 9'h110);
      chk("s1_ovf", ovf8, 0);
      @(negedge clk);
      in_valid8 = 0;
      @(posedge clk);
      #1;
      chk("s1_once", out_valid8, 0);
      chk("s1_hold", sum8, 9'h110);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
         in_valid8 = 1;
         model(8, longint'(a8), longint'(b8), cin8, sub8, sm8, ov8);
         @(posedge clk);
         #1;
         chk("s1_rand_sum", sum8, sm8[8:0]);
         chk("s1_rand_ovf", ovf8, ov8);
      end
      in_valid8 = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test, expected completion");
      $fatal(1);
   end

endmodule
